fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of requesters sharing one FIFO write port (fixed at 4 in this revision).
REQ-002 Parameter DATA_W, default 32, is the data word width, matching the FIFO data_in.
REQ-003 Parameter BURST_LEN, default 4, is the maximum number of words per grant (range 1..15).
REQ-004 Port clk, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit, is the reset: synchronous and active-low (0 = reset).
REQ-006 Port req_valid, input, NUM_REQ bits: bit i high means requester i offers a word.
REQ-007 Port req_data, input, NUM_REQ*DATA_W bits: requester i's word is at bits [i*DATA_W +: DATA_W].
REQ-008 Port req_ready, output, NUM_REQ bits: bit i high means requester i's word is accepted this cycle.
REQ-009 Port fifo_full, input, 1 bit, is the full flag from the FIFO.
REQ-010 Port fifo_wr, output, 1 bit, is the write enable to the FIFO.
REQ-011 Port fifo_data_in, output, DATA_W bits, is the write data to the FIFO.
REQ-012 Port grant_id, output, 2 bits, is the index of the requester currently granted.
REQ-013 Port busy, output, 1 bit, is high when the FSM is in BURST.

Function
REQ-014 The FSM SHALL have two states: IDLE and BURST.
REQ-015 In IDLE, if any req_valid bit is high and fifo_full=0, the block SHALL grant the first valid requester found round-robin, starting at last_grant+1 (mod 4), and then: load grant_id, clear beat_cnt, and go to BURST.
REQ-016 In IDLE, fifo_wr and all req_ready bits SHALL be 0, so arbitration costs exactly one cycle.
REQ-017 In BURST, a transfer SHALL occur in a cycle when req_valid[grant_id]=1 and fifo_full=0.
REQ-018 During a transfer, fifo_wr=1 and req_ready[grant_id]=1 SHALL be asserted combinationally in that same cycle, and fifo_data_in SHALL equal the granted requester's word.
REQ-019 req_ready bits of non-granted requesters SHALL always be 0, and at most one req_ready bit SHALL be high in any cycle.
REQ-020 beat_cnt (4 bits) SHALL increment on each transfer.
REQ-021 The burst SHALL end, returning to IDLE and setting last_grant to grant_id, on either:
- a transfer with beat_cnt = BURST_LEN-1; or
- a cycle in BURST with req_valid[grant_id]=0.
REQ-022 fifo_full=1 in BURST SHALL stall the burst: no transfer, state held, beat_cnt held, grant kept.
REQ-023 fifo_data_in SHALL present the granted requester's data whenever busy=1 (do-not-care qualified by fifo_wr), and 0 in IDLE.
REQ-024 Simultaneous requests SHALL never starve a requester: each valid requester SHALL be granted within 3 subsequent grants.

Reset
REQ-025 While reset=0 at a rising edge, the block SHALL set: state=IDLE, beat_cnt=0, grant_id=0, last_grant=3 (so requester 0 wins first), busy=0.
REQ-026 While reset=0, fifo_wr and req_ready SHALL be forced to 0 combinationally.
REQ-027 A reset asserted mid-burst SHALL abort the burst without any further write.

Configuration
REQ-028 Macro FIFO_WR_ARB_STATS_EN SHALL control the statistics feature.
REQ-029 When FIFO_WR_ARB_STATS_EN is defined, the block SHALL add output port word_count (16 bits), which:
- counts transfers;
- saturates at 16'hFFFF;
- clears to 0 on reset.
REQ-030 When FIFO_WR_ARB_STATS_EN is defined, the block SHALL add output port stall_count (16 bits), which:
- counts BURST cycles with fifo_full=1;
- saturates at 16'hFFFF;
- clears to 0 on reset.
REQ-031 Without the macro, neither port nor its logic SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-032 Scenario 1: reset=0 for 2 cycles then reset=1, with req_valid=4'b0000 -> busy=0, fifo_wr=0, grant_id=0.
REQ-033 Scenario 2: req_valid=4'b0001 held, BURST_LEN=4, fifo_full=0 -> 1 idle cycle, 4 writes, 1 idle cycle, 4 writes; grant_id=0 throughout.
REQ-034 Scenario 3: req_valid=4'b1111 held -> grant order 0,1,2,3,0; each grant gives 4 writes of that requester's data.
REQ-035 Scenario 4: requester 2 granted, fifo_full=1 after its 2nd write for 3 cycles -> fifo_wr=0 for those 3 cycles; grant held; writes 3 and 4 follow; then IDLE.
REQ-036 Scenario 5: requester 1 drops req_valid after 2 writes while requester 3 is valid -> return to IDLE after 2 writes; next grant=3.
REQ-037 Scenario 6: reset=0 in the cycle of a burst's 2nd write -> no fifo_wr that cycle; state=IDLE after the edge. With FIFO_WR_ARB_STATS_EN, word_count=0 after the edge.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Purpose
//   Shares one FIFO write port between NUM_REQ requesters. An idle cycle picks
//   the next valid requester round-robin (starting after the last one served).
//   The winner then owns the write port for a burst of up to BURST_LEN words.
//   A burst ends early when the granted requester stops offering data. A full
//   FIFO stalls the burst in place without losing the grant.
//
// Parameters
//   NUM_REQ    number of requesters (this revision supports exactly 4)
//   DATA_W     data word width, matches the FIFO data_in width
//   BURST_LEN  maximum words per grant, 1..15
//
// Ports
//   clk           in   single clock, rising edge
//   reset         in   synchronous reset, active low (0 = reset)
//   req_valid     in   [NUM_REQ]        requester i offers a word
//   req_data      in   [NUM_REQ*DATA_W] word of requester i at [i*DATA_W +: DATA_W]
//   req_ready     out  [NUM_REQ]        requester i's word is taken this cycle
//   fifo_full     in   FIFO full flag
//   fifo_wr       out  FIFO write enable
//   fifo_data_in  out  [DATA_W] FIFO write data (granted word while busy, else 0)
//   grant_id      out  [2] index of the granted requester
//   busy          out  high while a burst is in progress
//   word_count    out  [16] saturating count of words written    (stats build)
//   stall_count   out  [16] saturating count of stalled burst cycles (stats build)
//
// Configuration
//   FIFO_WR_ARB_STATS_EN  when defined, adds word_count and stall_count.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_data_in,
    output logic [1:0]                grant_id,
    output logic                      busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [15:0]               word_count,
    output logic [15:0]               stall_count
`endif
);

    localparam int IDX_W = 2;
    localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state_q;
    logic [3:0]       beat_cnt_q;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] last_grant_q;

    // -------------------------------------------------------------------------
    // Round-robin pick: first valid requester at or after last_grant+1.
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] rr_pick;
    logic             rr_found;

    always_comb begin
        logic [IDX_W-1:0] idx;
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        rr_pick  = last_grant_q + 2'd1;
        rr_found = 1'b0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = last_grant_q + 2'd1 + IDX_W'(k);
            if (!rr_found && req_valid[idx]) begin
                rr_pick  = idx;
                rr_found = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Transfer qualification. Reset low kills the handshake immediately so a
    // burst interrupted by reset never writes one more word.
    // -------------------------------------------------------------------------
    logic granted_valid;
    logic xfer;
    logic last_beat;

    assign granted_valid = req_valid[grant_q];
    assign xfer          = reset && (state_q == BURST) && granted_valid && !fifo_full;
    assign last_beat     = (beat_cnt_q == LAST_BEAT);

    assign fifo_wr   = xfer;
    assign req_ready = xfer ? (NUM_REQ'(1) << grant_q) : '0;
    assign grant_id  = grant_q;
    assign busy      = (state_q == BURST);

    // Data follows the grant for the whole burst; zero while idle.
    assign fifo_data_in = busy ? req_data[grant_q*DATA_W +: DATA_W] : '0;

    // -------------------------------------------------------------------------
    // Arbitration / burst FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!reset) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            grant_q      <= '0;
            last_grant_q <= 2'd3;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rr_found && !fifo_full) begin
                        grant_q    <= rr_pick;
                        beat_cnt_q <= '0;
                        state_q    <= BURST;
                    end
                end

                BURST: begin
                    if (!granted_valid) begin
                        // Requester went away: release the port, even if the
                        // FIFO is full, since there is nothing left to wait for.
                        state_q      <= IDLE;
                        last_grant_q <= grant_q;
                    end else if (!fifo_full) begin
                        beat_cnt_q <= beat_cnt_q + 4'd1;
                        if (last_beat) begin
                            state_q      <= IDLE;
                            last_grant_q <= grant_q;
                        end
                    end
                    // fifo_full with data pending: hold state, beat and grant.
                end

                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    // -------------------------------------------------------------------------
    // Saturating statistics counters
    // -------------------------------------------------------------------------
    logic [15:0] word_count_q,  word_count_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic        stall_cycle;

    assign stall_cycle = (state_q == BURST) && fifo_full;

    always_comb begin
        word_count_d  = word_count_q;
        stall_count_d = stall_count_q;
        if (xfer && (word_count_q != 16'hFFFF)) begin
            word_count_d = word_count_q + 16'd1;
        end
        if (stall_cycle && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            word_count_q  <= '0;
            stall_count_q <= '0;
        end else begin
            word_count_q  <= word_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign word_count  = word_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      fifo_wr;
    logic [DATA_W-1:0]         fifo_data_in;
    logic [1:0]                grant_id;
    logic                      busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0]               word_count;
    logic [15:0]               stall_count;
`endif

    fifo_wr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .BURST_LEN(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wr     (fifo_wr),
        .fifo_data_in(fifo_data_in),
        .grant_id    (grant_id),
        .busy        (busy)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .word_count  (word_count),
        .stall_count (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   sent  [NUM_REQ];
    int   exp_k [NUM_REQ];

    // Word number k offered by requester i: top nibble tags the requester.
    function automatic logic [31:0] word_of(input int i, input int k);
        return {4'(i + 1), 28'(k)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*DATA_W +: DATA_W] = word_of(i, sent[i]);
        end
    endtask

    // Expected writes of requester i, in the order the spec predicts.
    task automatic push_burst(input int i, input int n);
        for (int j = 0; j < n; j++) begin
            q.push_back('{id: 2'(i), data: word_of(i, exp_k[i])});
            exp_k[i]++;
        end
    endtask

    // One clock cycle: check the combinational outputs against exp_wr and the
    // scoreboard, then advance past the edge and update the requester sources.
    task automatic cyc(input logic exp_wr, input string tag);
        logic [3:0] acc;
        logic [3:0] oh;
        exp_t       e;
        #1;
        check({tag, "_wr"}, 32'(fifo_wr), 32'(exp_wr));
        if (fifo_wr === 1'b1) begin
            check({tag, "_sb_has"}, 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e  = q.pop_front();
                oh = 4'b0001 << e.id;
                check({tag, "_data"},  fifo_data_in, e.data);
                check({tag, "_gid"},   32'(grant_id), 32'(e.id));
                check({tag, "_ready"}, 32'(req_ready), 32'(oh));
            end
        end else begin
            check({tag, "_ready0"}, 32'(req_ready), 32'd0);
        end
        acc = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i] === 1'b1) sent[i]++;
        end
        drive_data();
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            sent[i]  = 0;
            exp_k[i] = 0;
        end
        reset     = 1'b0;
        req_valid = '0;
        fifo_full = 1'b0;
        drive_data();
        @(posedge clk);
        #1;

        // Scenario 1: reset low for two edges, no requests.
        cyc(1'b0, "s1_rst");
        reset = 1'b1;
        check("s1_busy", 32'(busy), 32'd0);
        check("s1_gid",  32'(grant_id), 32'd0);
        check("s1_data", fifo_data_in, 32'd0);
        cyc(1'b0, "s1_idle");
        check("s1_busy_idle", 32'(busy), 32'd0);

        // Scenario 2: single requester 0, two full bursts separated by one idle.
        req_valid = 4'b0001;
        push_burst(0, 8);
        cyc(1'b0, "s2_arb0");
        check("s2_busy", 32'(busy), 32'd1);
        for (int j = 0; j < 4; j++) cyc(1'b1, "s2_b0");
        check("s2_idle_busy", 32'(busy), 32'd0);
        cyc(1'b0, "s2_arb1");
        for (int j = 0; j < 4; j++) cyc(1'b1, "s2_b1");
        req_valid = 4'b0000;
        cyc(1'b0, "s2_end");
        check("s2_gid", 32'(grant_id), 32'd0);
`ifdef FIFO_WR_ARB_STATS_EN
        check("s2_wcount", 32'(word_count), 32'd8);
        check("s2_scount", 32'(stall_count), 32'd0);
`endif

        // Scenario 3: all requesters valid after reset -> order 0,1,2,3,0.
        reset = 1'b0;
        cyc(1'b0, "s3_rst");
        reset = 1'b1;
        check("s3_gid_rst", 32'(grant_id), 32'd0);
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            push_burst(n % 4, 4);
            cyc(1'b0, "s3_arb");
            check("s3_gid", 32'(grant_id), 32'(n % 4));
            for (int j = 0; j < 4; j++) cyc(1'b1, "s3_beat");
        end
        req_valid = 4'b0000;
        cyc(1'b0, "s3_end");

        // Scenario 4: requester 2 stalled by fifo_full after its 2nd write.
        req_valid = 4'b0100;
        push_burst(2, 4);
        cyc(1'b0, "s4_arb");
        check("s4_gid", 32'(grant_id), 32'd2);
        cyc(1'b1, "s4_w1");
        cyc(1'b1, "s4_w2");
        fifo_full = 1'b1;
        for (int j = 0; j < 3; j++) begin
            cyc(1'b0, "s4_stall");
            check("s4_stall_gid",  32'(grant_id), 32'd2);
            check("s4_stall_busy", 32'(busy), 32'd1);
        end
        fifo_full = 1'b0;
        cyc(1'b1, "s4_w3");
        cyc(1'b1, "s4_w4");
        check("s4_idle", 32'(busy), 32'd0);
        req_valid = 4'b0000;
        cyc(1'b0, "s4_end");
`ifdef FIFO_WR_ARB_STATS_EN
        check("s4_wcount", 32'(word_count), 32'd24);
        check("s4_scount", 32'(stall_count), 32'd3);
`endif

        // Scenario 5: requester 1 drops after 2 writes, requester 3 waiting.
        reset = 1'b0;
        cyc(1'b0, "s5_rst");
        reset = 1'b1;
        req_valid = 4'b1010;
        push_burst(1, 2);
        cyc(1'b0, "s5_arb1");
        check("s5_gid1", 32'(grant_id), 32'd1);
        cyc(1'b1, "s5_w1");
        cyc(1'b1, "s5_w2");
        req_valid = 4'b1000;
        cyc(1'b0, "s5_drop");
        check("s5_drop_idle", 32'(busy), 32'd0);
        push_burst(3, 4);
        cyc(1'b0, "s5_arb3");
        check("s5_gid3", 32'(grant_id), 32'd3);
        for (int j = 0; j < 4; j++) cyc(1'b1, "s5_b3");
        req_valid = 4'b0000;
        cyc(1'b0, "s5_end");

        // Scenario 6: reset in the cycle of a burst's 2nd write.
        reset = 1'b0;
        cyc(1'b0, "s6_rst");
        reset = 1'b1;
        req_valid = 4'b0001;
        push_burst(0, 1);
        cyc(1'b0, "s6_arb");
        cyc(1'b1, "s6_w1");
        reset = 1'b0;
        cyc(1'b0, "s6_abort");
        check("s6_busy", 32'(busy), 32'd0);
        check("s6_gid",  32'(grant_id), 32'd0);
`ifdef FIFO_WR_ARB_STATS_EN
        check("s6_wcount", 32'(word_count), 32'd0);
        check("s6_scount", 32'(stall_count), 32'd0);
`endif
        reset = 1'b1;
        push_burst(0, 4);
        cyc(1'b0, "s6_rearb");
        for (int j = 0; j < 4; j++) cyc(1'b1, "s6_b");
        req_valid = 4'b0000;
        cyc(1'b0, "s6_end");
`ifdef FIFO_WR_ARB_STATS_EN
        check("s6_wcount_end", 32'(word_count), 32'd4);
`endif

        check("sb_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
